// File: rtl/mult_radix4_iter_if.sv
// Handshake/operand bundle for the iterative radix-4 multiplier.
// master = issue logic side, slave = multiplier side.
interface mult_radix4_iter_if #(
    parameter int WIDTH = 32
);
    logic                 mult_begin;
    logic                 mult_signed;
    logic [WIDTH-1:0]     mult_op1;
    logic [WIDTH-1:0]     mult_op2;
    logic [2*WIDTH-1:0]   product;
    logic                 mult_end;
    logic                 mult_busy;

    modport master (
        output mult_begin, mult_signed, mult_op1, mult_op2,
        input  product, mult_end, mult_busy
    );

    modport slave (
        input  mult_begin, mult_signed, mult_op1, mult_op2,
        output product, mult_end, mult_busy
    );
endinterface

// File: rtl/mult_radix4_iter.sv
// Iterative radix-4 WIDTHxWIDTH multiplier (signed/unsigned), IDLE->CALC->DONE FSM.
// Optional MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mult_radix4_iter #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              resetn,
    mult_radix4_iter_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
        $error("mult_radix4_iter: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    prod_r;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [CW-1:0]    count;
    logic             neg;
    logic             last;

    // Magnitudes in signed mode; the most negative value wraps to 2^(WIDTH-1) unsigned.
    assign abs1 = (bus.mult_signed && bus.mult_op1[WIDTH-1]) ? -bus.mult_op1 : bus.mult_op1;
    assign abs2 = (bus.mult_signed && bus.mult_op2[WIDTH-1]) ? -bus.mult_op2 : bus.mult_op2;

    always_comb begin
        pp = '0;
        unique case (mplier[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = mcand;
            2'b10:   pp = mcand << 1;
            default: pp = mcand + (mcand << 1);
        endcase
        acc_nxt = acc + pp;
    end

`ifdef MULT_EARLY_TERM_EN
    assign last = (count == CW'(STEPS - 1)) || ((mplier >> 2) == '0);
`else
    assign last = (count == CW'(STEPS - 1));
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.mult_begin) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            prod_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.mult_begin) begin
                        mcand  <= {{WIDTH{1'b0}}, abs1};
                        mplier <= abs2;
                        acc    <= '0;
                        count  <= '0;
                        neg    <= bus.mult_signed & (bus.mult_op1[WIDTH-1] ^ bus.mult_op2[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    count  <= count + CW'(1);
                    if (last) prod_r <= neg ? -acc_nxt : acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.product   = prod_r;
    assign bus.mult_end  = (state == DONE);
    assign bus.mult_busy = (state != IDLE);
endmodule

// File: tb/tb_mult_radix4_iter.sv
// Scoreboard bench for mult_radix4_iter (WIDTH=32): directed vectors, latency and hold checks.
module tb_mult_radix4_iter;
    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] p;
        int             start;
        int             lat;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done_req = 1'b0;
    bit   mon_done = 1'b0;
    logic [2*W-1:0] last_prod = '0;
    exp_t q[$];

    mult_radix4_iter_if #(.WIDTH(W)) bus ();

    mult_radix4_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected CALC cycles: fixed WIDTH/2, or multiplier bit-length/2 with early termination.
    function automatic int exp_lat(input logic s, input logic [W-1:0] b);
        logic [W-1:0] m;
        int bl;
        int n;
        m  = (s && b[W-1]) ? -b : b;
        bl = 0;
        for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
        n = (bl + 1) / 2;
        if (n < 1) n = 1;
`ifndef MULT_EARLY_TERM_EN
        n = W / 2;
`endif
        return n;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            checks++;
            if (bus.mult_busy !== 1'b0 || bus.mult_end !== 1'b0 || bus.product !== '0) begin
                errors++;
                $display("FAIL reset_state: busy=%b end=%b product=%h required 0/0/0",
                         bus.mult_busy, bus.mult_end, bus.product);
            end
            q.delete();
            last_prod = '0;
        end else if (bus.mult_end === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_end: mult_end at cycle %0d with no pending op", cyc);
            end else begin
                e = q.pop_front();
                if (bus.product !== e.p) begin
                    errors++;
                    $display("FAIL product: got %h required %h", bus.product, e.p);
                end
                checks++;
                if (cyc - e.start != e.lat) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", cyc - e.start, e.lat);
                end
                last_prod = e.p;
            end
        end else begin
            checks++;
            if (bus.product !== last_prod) begin
                errors++;
                $display("FAIL product_hold: got %h required %h at cycle %0d",
                         bus.product, last_prod, cyc);
            end
        end
        if (done_req && !mon_done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL pending_ops: got %0d outstanding required 0", q.size());
            end
            mon_done = 1'b1;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.mult_busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL idle_timeout: busy still %b after %0d cycles required 0", bus.mult_busy, n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p);
        exp_t e;
        wait_idle();
        bus.mult_signed = s;
        bus.mult_op1    = a;
        bus.mult_op2    = b;
        bus.mult_begin  = 1'b1;
        e.p     = exp_p;
        e.start = cyc + 1;
        e.lat   = exp_lat(s, b);
        q.push_back(e);
        @(negedge clk);
        bus.mult_begin  = 1'b0;
        bus.mult_signed = ~s;
        bus.mult_op1    = ~a;
        bus.mult_op2    = b ^ 32'hDEAD_BEEF;
    endtask

    initial begin
        int g;
        int c;
        int n;
        exp_t e;
        bus.mult_begin  = 1'b0;
        bus.mult_signed = 1'b0;
        bus.mult_op1    = '0;
        bus.mult_op2    = '0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;

        issue(1'b1, 32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1);
        issue(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        issue(1'b1, 32'h80000000, 32'h1, 64'hFFFFFFFF_80000000);
        issue(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
        issue(1'b1, 32'd100, -32'sd100, 64'hFFFFFFFF_FFFFD8F0);
        issue(1'b0, 32'h80000000, 32'd2, 64'h1_00000000);
        issue(1'b0, 32'd5, 32'd3, 64'd15);
        issue(1'b1, 32'd9, 32'd0, 64'd0);

        // Reset in the middle of CALC; the flushed op must never complete.
        issue(1'b1, 32'd123, 32'd456, 64'd56088);
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        issue(1'b0, 32'd5, 32'd6, 64'd30);

        // Begin pulsed during CALC and during DONE must be ignored.
        issue(1'b0, 32'd1000, 32'd1000, 64'd1000000);
        repeat (2) @(negedge clk);
        bus.mult_op1   = 32'd77;
        bus.mult_op2   = 32'd77;
        bus.mult_begin = 1'b1;
        @(negedge clk);
        bus.mult_begin = 1'b0;
        n = 0;
        while (bus.mult_end !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                $display("FAIL end_timeout: mult_end=%b after %0d cycles required 1", bus.mult_end, n);
                $fatal(1, "timeout");
            end
        end
        bus.mult_begin = 1'b1;
        @(negedge clk);
        bus.mult_begin = 1'b0;
        repeat (4) @(negedge clk);

        // Begin held high: three back-to-back ops at the full issue rate.
        wait_idle();
        g = exp_lat(1'b0, 32'd7) + 2;
        c = cyc;
        bus.mult_signed = 1'b0;
        bus.mult_op1    = 32'd6;
        bus.mult_op2    = 32'd7;
        bus.mult_begin  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.p     = 64'd42;
            e.start = c + 1 + k * g;
            e.lat   = exp_lat(1'b0, 32'd7);
            q.push_back(e);
        end
        repeat (2 * g + 1) @(posedge clk);
        @(negedge clk);
        bus.mult_begin = 1'b0;

        wait_idle();
        repeat (3) @(negedge clk);
        done_req = 1'b1;
        n = 0;
        while (!mon_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
